// File: rtl/mandelbrot_host_ctrl.sv
// ---------------------------------------------------------------------------
// mandelbrot_host_ctrl
//   Initiator for the mandelbrot engine control pins. It takes one pixel job
//   from a valid/ready command port and shifts the configuration word
//   {scaling, ci, cr} into the engine MSB first. It then raises run and waits
//   for a rising edge on finished. The 7-bit iteration count is read back as
//   two nibbles through ctr_select. The count, or a timeout indication, is
//   returned on a valid/ready result port.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     job handshake (ready only while idle)
//   cmd_scaling/cr/ci   job parameters, captured on acceptance
//   res_valid/ready     result handshake (valid held until ready)
//   res_ctr/res_timeout iteration count / finished-never-arrived flag
//   shift_en/shift_data engine configuration serial port
//   run                 engine run request
//   ctr_select/ctr_in   nibble select toward the engine / nibble returned
//   finished            engine done flag
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module mandelbrot_host_ctrl #(
   parameter int CFG_BITS = 24,
   parameter int CTRWIDTH = 7,
   parameter int TIMEOUT  = 4095,
   parameter int SETTLE   = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_scaling,
   input  logic [10:0]         cmd_cr,
   input  logic [10:0]         cmd_ci,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [CTRWIDTH-1:0] res_ctr,
   output logic                res_timeout,
   output logic                shift_en,
   output logic                shift_data,
   output logic                run,
   output logic [1:0]          ctr_select,
   input  logic [3:0]          ctr_in,
   input  logic                finished
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int BW = $clog2(CFG_BITS);
   localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_START,
      S_WAIT,
      S_READ_LO,
      S_READ_HI,
      S_RESULT
   } state_t;

   state_t                state_q, state_d;
   logic [CFG_BITS-1:0]   word_q, word_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [TW-1:0]         tcnt_q, tcnt_d;
   logic [SW-1:0]         scnt_q, scnt_d;
   logic                  fin_q, fin_d;

   logic                  cmd_ready_q, cmd_ready_d;
   logic                  res_valid_q, res_valid_d;
   logic [CTRWIDTH-1:0]   res_ctr_q, res_ctr_d;
   logic                  res_timeout_q, res_timeout_d;
   logic                  shift_en_q, shift_en_d;
   logic                  shift_data_q, shift_data_d;
   logic                  run_q, run_d;
   logic [1:0]            ctr_select_q, ctr_select_d;

   logic [CFG_BITS-1:0]   cmd_word;
   logic                  unused_ctr_bits;

   assign cmd_word = {cmd_scaling, cmd_ci, cmd_cr};

   // The top nibble bits above the counter width carry nothing useful.
   assign unused_ctr_bits = ^ctr_in[3:CTRWIDTH-4];

   always_comb begin
      state_d       = state_q;
      word_d        = word_q;
      bit_d         = bit_q;
      tcnt_d        = tcnt_q;
      scnt_d        = scnt_q;
      fin_d         = fin_q;
      res_valid_d   = res_valid_q;
      res_ctr_d     = res_ctr_q;
      res_timeout_d = res_timeout_q;
      shift_en_d    = shift_en_q;
      shift_data_d  = shift_data_q;
      run_d         = run_q;
      ctr_select_d  = ctr_select_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               // The MSB goes out immediately. The remainder is held
               // pre-shifted so that each step only reads the top bit.
               shift_en_d   = 1'b1;
               shift_data_d = cmd_word[CFG_BITS-1];
               word_d       = {cmd_word[CFG_BITS-2:0], 1'b0};
               bit_d        = '0;
               state_d      = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (bit_q == BW'(CFG_BITS - 1)) begin
               shift_en_d   = 1'b0;
               shift_data_d = 1'b0;
               run_d        = 1'b1;
               state_d      = S_START;
            end else begin
               shift_data_d = word_q[CFG_BITS-1];
               word_d       = {word_q[CFG_BITS-2:0], 1'b0};
               bit_d        = bit_q + 1'b1;
            end
         end
         S_START: begin
            // Record the finished level now so a level left from the
            // previous job is not mistaken for completion.
            fin_d   = finished;
            tcnt_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            fin_d = finished;
            if (!fin_q && finished) begin
               run_d        = 1'b0;
               ctr_select_d = 2'd0;
               scnt_d       = '0;
               state_d      = S_READ_LO;
            end else if (tcnt_q == TW'(TIMEOUT)) begin
               run_d         = 1'b0;
               res_ctr_d     = '0;
               res_timeout_d = 1'b1;
               res_valid_d   = 1'b1;
               state_d       = S_RESULT;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         S_READ_LO: begin
            if (scnt_q == SW'(SETTLE)) begin
               res_ctr_d[3:0] = ctr_in;
               ctr_select_d   = 2'd1;
               scnt_d         = '0;
               state_d        = S_READ_HI;
            end else begin
               scnt_d = scnt_q + 1'b1;
            end
         end
         S_READ_HI: begin
            if (scnt_q == SW'(SETTLE)) begin
               res_ctr_d[CTRWIDTH-1:4] = ctr_in[CTRWIDTH-5:0];
               ctr_select_d            = 2'd0;
               res_timeout_d           = 1'b0;
               res_valid_d             = 1'b1;
               state_d                 = S_RESULT;
            end else begin
               scnt_d = scnt_q + 1'b1;
            end
         end
         S_RESULT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Ready is registered. It therefore reflects the state being entered.
      cmd_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         word_q        <= '0;
         bit_q         <= '0;
         tcnt_q        <= '0;
         scnt_q        <= '0;
         fin_q         <= 1'b0;
         cmd_ready_q   <= 1'b0;
         res_valid_q   <= 1'b0;
         res_ctr_q     <= '0;
         res_timeout_q <= 1'b0;
         shift_en_q    <= 1'b0;
         shift_data_q  <= 1'b0;
         run_q         <= 1'b0;
         ctr_select_q  <= 2'd0;
      end else begin
         state_q       <= state_d;
         word_q        <= word_d;
         bit_q         <= bit_d;
         tcnt_q        <= tcnt_d;
         scnt_q        <= scnt_d;
         fin_q         <= fin_d;
         cmd_ready_q   <= cmd_ready_d;
         res_valid_q   <= res_valid_d;
         res_ctr_q     <= res_ctr_d;
         res_timeout_q <= res_timeout_d;
         shift_en_q    <= shift_en_d;
         shift_data_q  <= shift_data_d;
         run_q         <= run_d;
         ctr_select_q  <= ctr_select_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign res_valid   = res_valid_q;
   assign res_ctr     = res_ctr_q;
   assign res_timeout = res_timeout_q;
   assign shift_en    = shift_en_q;
   assign shift_data  = shift_data_q;
   assign run         = run_q;
   assign ctr_select  = ctr_select_q;

endmodule

// File: tb/tb_mandelbrot_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mandelbrot_host_ctrl
//   Drives pixel jobs into mandelbrot_host_ctrl against a small engine model.
//   The model holds an iteration count, returns nibbles by ctr_select and
//   raises finished after a programmable delay. Expected values come from
//   the job parameters: the shifted word is {scaling, ci, cr}, and the
//   result is the model count or a timeout.
// ---------------------------------------------------------------------------
module tb_mandelbrot_host_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_scaling = '0;
   logic [10:0] cmd_cr = '0;
   logic [10:0] cmd_ci = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [6:0]  res_ctr;
   logic        res_timeout;
   logic        shift_en;
   logic        shift_data;
   logic        run;
   logic [1:0]  ctr_select;
   logic [3:0]  ctr_in;
   logic        finished = 1'b0;

   // engine model
   logic [6:0]  eng_ctr = '0;
   logic        eng_junk = 1'b0;
   assign ctr_in = (ctr_select == 2'd0) ? eng_ctr[3:0] : {eng_junk, eng_ctr[6:4]};

   int total = 0;
   int bad   = 0;

   // results collected by do_job
   logic [23:0] cap_word;
   int          cap_n;
   logic        run_after;
   logic        run_after_edge;
   logic        ready_in_job;
   logic        got_valid;
   int          done_n;
   logic [6:0]  r_ctr;
   logic        r_to;

   always #5 clk = ~clk;

   mandelbrot_host_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_scaling (cmd_scaling),
      .cmd_cr      (cmd_cr),
      .cmd_ci      (cmd_ci),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_ctr     (res_ctr),
      .res_timeout (res_timeout),
      .shift_en    (shift_en),
      .shift_data  (shift_data),
      .run         (run),
      .ctr_select  (ctr_select),
      .ctr_in      (ctr_in),
      .finished    (finished)
   );

   // Runs one job up to res_valid (or a bound). fin_delay < 0 never raises finished.
   task automatic do_job(input logic [1:0] sc, input logic [10:0] cr, input logic [10:0] ci,
                         input int fin_delay, input bit scramble, input logic fin_init);
      int n;
      finished = fin_init;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      cmd_valid   = 1'b1;
      cmd_scaling = sc;
      cmd_cr      = cr;
      cmd_ci      = ci;
      @(negedge clk);
      if (!scramble) cmd_valid = 1'b0;
      cap_word     = '0;
      cap_n        = 0;
      ready_in_job = 1'b0;
      n = 0;
      while (shift_en === 1'b1 && n < 40) begin
         cap_word = {cap_word[22:0], shift_data};
         cap_n++;
         if (cmd_ready === 1'b1) ready_in_job = 1'b1;
         if (scramble) begin
            cmd_valid   = 1'($urandom);
            cmd_scaling = 2'($urandom);
            cmd_cr      = 11'($urandom);
            cmd_ci      = 11'($urandom);
         end
         @(negedge clk);
         n++;
      end
      run_after      = run;
      cmd_valid      = 1'b0;
      run_after_edge = 1'bx;
      n = 0;
      while (res_valid !== 1'b1 && n < 5000) begin
         if (fin_delay >= 0 && n == fin_delay) finished = 1'b1;
         if (cmd_ready === 1'b1) ready_in_job = 1'b1;
         @(negedge clk);
         n++;
         if (fin_delay >= 0 && n == fin_delay + 1) run_after_edge = run;
      end
      done_n    = n;
      got_valid = (res_valid === 1'b1);
      r_ctr     = res_ctr;
      r_to      = res_timeout;
   endtask

   task automatic release_result();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++;
      if ({cmd_ready, res_valid, res_ctr, res_timeout, shift_en, shift_data, run, ctr_select} !== 15'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want all zero",
                  {cmd_ready, res_valid, res_ctr, res_timeout, shift_en, shift_data, run, ctr_select});
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || run !== 1'b0) begin
         bad++;
         $display("FAIL reset_first_idle: cmd_ready=%b res_valid=%b run=%b want 1 0 0", cmd_ready, res_valid, run);
      end
   endtask

   task automatic test_shift();
      logic [23:0] exp;
      eng_ctr = 7'($urandom);
      exp = {2'b10, 11'h2AA, 11'h155};
      do_job(2'b10, 11'h155, 11'h2AA, 10, 1'b0, 1'b0);
      total++;
      if (cap_n != 24 || cap_word !== exp) begin
         bad++;
         $display("FAIL shift_word: got %0d bits %h want 24 bits %h", cap_n, cap_word, exp);
      end
      total++;
      if (run_after !== 1'b1) begin
         bad++;
         $display("FAIL run_after_shift: got %b want 1", run_after);
      end
      total++;
      if (ready_in_job !== 1'b0) begin
         bad++;
         $display("FAIL cmd_ready_busy: got %b want 0", ready_in_job);
      end
      total++;
      if (!got_valid || r_ctr !== eng_ctr || r_to !== 1'b0) begin
         bad++;
         $display("FAIL shift_result: valid=%b ctr=%h to=%b want 1 %h 0", got_valid, r_ctr, r_to, eng_ctr);
      end
      release_result();
   endtask

   task automatic test_readback();
      eng_ctr  = 7'h5B;
      eng_junk = 1'b1;
      do_job(2'($urandom), 11'($urandom), 11'($urandom), 40, 1'b0, 1'b0);
      total++;
      if (!got_valid || r_ctr !== 7'h5B || r_to !== 1'b0) begin
         bad++;
         $display("FAIL readback: valid=%b ctr=%h to=%b want 1 5b 0", got_valid, r_ctr, r_to);
      end
      total++;
      if (run_after_edge !== 1'b0) begin
         bad++;
         $display("FAIL run_drop: got %b want 0", run_after_edge);
      end
      // edge cycle, two settle+sample reads, then the result register
      total++;
      if (done_n - 40 != 5) begin
         bad++;
         $display("FAIL readback_latency: got %0d want 5", done_n - 40);
      end
      eng_junk = 1'b0;
      release_result();
   endtask

   task automatic test_timeout();
      eng_ctr = 7'h7F;
      do_job(2'b01, 11'h7FF, 11'h001, -1, 1'b0, 1'b1);
      total++;
      if (!got_valid || r_to !== 1'b1 || r_ctr !== 7'd0) begin
         bad++;
         $display("FAIL timeout_result: valid=%b to=%b ctr=%h want 1 1 0", got_valid, r_to, r_ctr);
      end
      total++;
      if (done_n < 4095 || done_n > 4099) begin
         bad++;
         $display("FAIL timeout_cycles: got %0d want about 4096", done_n);
      end
      total++;
      if (run !== 1'b0) begin
         bad++;
         $display("FAIL timeout_run: got %b want 0", run);
      end
      release_result();
   endtask

   task automatic test_hold();
      logic [6:0] exp;
      exp = 7'($urandom);
      eng_ctr = exp;
      do_job(2'($urandom), 11'($urandom), 11'($urandom), 7, 1'b0, 1'b0);
      eng_ctr = ~exp;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (res_valid !== 1'b1 || res_ctr !== exp || res_timeout !== 1'b0) begin
            bad++;
            $display("FAIL hold_%0d: valid=%b ctr=%h to=%b want 1 %h 0", i, res_valid, res_ctr, res_timeout, exp);
         end
      end
      release_result();
      total++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL hold_release: valid=%b cmd_ready=%b want 0 1", res_valid, cmd_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0]  sc;
      logic [10:0] cr;
      logic [10:0] ci;
      int n;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      cmd_valid   = 1'b1;
      cmd_scaling = 2'b11;
      cmd_cr      = 11'h3C3;
      cmd_ci      = 11'h0F0;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (shift_en === 1'b1 && n < 12) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (shift_en !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid_shift_active: got %b want 1", shift_en);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({cmd_ready, res_valid, res_ctr, res_timeout, shift_en, shift_data, run, ctr_select} !== 15'd0) begin
         bad++;
         $display("FAIL reset_mid_outputs: got %b want all zero",
                  {cmd_ready, res_valid, res_ctr, res_timeout, shift_en, shift_data, run, ctr_select});
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b1 || shift_en !== 1'b0 || res_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_idle: cmd_ready=%b shift_en=%b res_valid=%b want 1 0 0", cmd_ready, shift_en, res_valid);
      end
      sc = 2'($urandom);
      cr = 11'($urandom);
      ci = 11'($urandom);
      eng_ctr = 7'($urandom);
      do_job(sc, cr, ci, 3, 1'b0, 1'b0);
      total++;
      if (cap_n != 24 || cap_word !== {sc, ci, cr}) begin
         bad++;
         $display("FAIL reset_mid_fresh: got %0d bits %h want 24 bits %h", cap_n, cap_word, {sc, ci, cr});
      end
      total++;
      if (!got_valid || r_ctr !== eng_ctr) begin
         bad++;
         $display("FAIL reset_mid_result: valid=%b ctr=%h want 1 %h", got_valid, r_ctr, eng_ctr);
      end
      release_result();
   endtask

   task automatic test_scramble();
      logic [1:0]  sc;
      logic [10:0] cr;
      logic [10:0] ci;
      for (int j = 0; j < 2; j++) begin
         sc = 2'($urandom);
         cr = 11'($urandom);
         ci = 11'($urandom);
         eng_ctr = 7'($urandom);
         do_job(sc, cr, ci, 5, 1'b1, 1'b0);
         total++;
         if (cap_n != 24 || cap_word !== {sc, ci, cr}) begin
            bad++;
            $display("FAIL scramble_word_%0d: got %0d bits %h want %h", j, cap_n, cap_word, {sc, ci, cr});
         end
         total++;
         if (!got_valid || r_ctr !== eng_ctr || r_to !== 1'b0) begin
            bad++;
            $display("FAIL scramble_result_%0d: valid=%b ctr=%h to=%b want 1 %h 0", j, got_valid, r_ctr, r_to, eng_ctr);
         end
         release_result();
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  sc;
      logic [10:0] cr;
      logic [10:0] ci;
      int          d;
      for (int j = 0; j < 6; j++) begin
         sc = 2'($urandom);
         cr = 11'($urandom);
         ci = 11'($urandom);
         d  = int'($urandom_range(60, 1));
         eng_ctr  = 7'($urandom);
         eng_junk = 1'($urandom);
         do_job(sc, cr, ci, d, 1'b0, 1'b0);
         total++;
         if (cap_n != 24 || cap_word !== {sc, ci, cr}) begin
            bad++;
            $display("FAIL b2b_word_%0d: got %0d bits %h want %h", j, cap_n, cap_word, {sc, ci, cr});
         end
         total++;
         if (!got_valid || r_ctr !== eng_ctr || r_to !== 1'b0 || done_n != d + 5) begin
            bad++;
            $display("FAIL b2b_result_%0d: valid=%b ctr=%h to=%b lat=%0d want 1 %h 0 %0d",
                     j, got_valid, r_ctr, r_to, done_n, eng_ctr, d + 5);
         end
         release_result();
      end
   endtask

   initial begin
      test_reset();
      test_shift();
      test_readback();
      test_timeout();
      test_hold();
      test_reset_mid();
      test_scramble();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
